// File: rtl/segdisplay_arbiter.sv
// Leased round-robin arbiter for the seven-segment display write port.
// A requester that wins keeps the port until it stays quiet for HOLD_CYCLES
// cycles or releases it, so a written value stays visible long enough to read.
module segdisplay_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [NUM_REQ-1:0]                 valid_i,
  input  logic [NUM_REQ-1:0][31:0]           data_i,
  input  logic [NUM_REQ-1:0][3:0]            mask_i,
  input  logic [NUM_REQ-1:0]                 release_i,
  output logic [NUM_REQ-1:0]                 ready_o,
  output logic [31:0]                        write_data_o,
  output logic [3:0]                         write_mask_o,
  output logic                               owner_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]         owner_o
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int LW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [LW-1:0] lease_r;
  logic [OW-1:0] last_owner_r;
  logic [OW-1:0] win_idx;
  logic          win_found;
  logic [OW:0]   scan_idx;
  logic [OW-1:0] xfer_idx;
  logic          xfer;

  // Round-robin scan starting just after the last owner, so the previous
  // owner is considered last and nobody starves.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = {1'b0, last_owner_r} + (OW+1)'(i);
      if (scan_idx >= (OW+1)'(NUM_REQ))
        scan_idx = scan_idx - (OW+1)'(NUM_REQ);
      if (!win_found && valid_i[scan_idx[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[OW-1:0];
      end
    end
  end

  // One-hot ready: the owner while leased, otherwise the scan winner.
  always_comb begin
    ready_o = '0;
    if (!reset_i) begin
      if (state == OWNED)
        ready_o[owner_o] = 1'b1;
      else if (win_found)
        ready_o[win_idx] = 1'b1;
    end
  end

  assign xfer          = |(valid_i & ready_o);
  assign xfer_idx      = (state == OWNED) ? owner_o : win_idx;
  assign owner_valid_o = (state == OWNED);

  // Lease FSM plus the registered display write port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      lease_r      <= '0;
      last_owner_r <= OW'(NUM_REQ - 1);
      owner_o      <= OW'(NUM_REQ - 1);
      write_data_o <= '0;
      write_mask_o <= '0;
    end else begin
      write_mask_o <= '0;
      if (xfer) begin
        write_data_o <= data_i[xfer_idx];
        write_mask_o <= mask_i[xfer_idx];
      end
      case (state)
        IDLE: begin
          if (xfer) begin
            state   <= OWNED;
            owner_o <= win_idx;
            lease_r <= LW'(HOLD_CYCLES);
          end
        end
        OWNED: begin
          // Release wins over the lease; a simultaneous write still went out above.
          if (release_i[owner_o]) begin
            state        <= IDLE;
            last_owner_r <= owner_o;
            lease_r      <= '0;
          end else if (xfer) begin
            lease_r <= LW'(HOLD_CYCLES);
          end else if (lease_r == LW'(1)) begin
            state        <= IDLE;
            last_owner_r <= owner_o;
            lease_r      <= '0;
          end else begin
            lease_r <= lease_r - LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
